// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM model.
package sram_pkg;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    // Widest word the shared merge helper handles; callers zero-extend into it.
    localparam int unsigned MAX_DATA_WIDTH = 1024;

    typedef logic [MAX_DATA_WIDTH-1:0] word_t;

    // Take new_word on bits whose mask bit is set, keep old_word elsewhere.
    // The mask is already expanded from byte lanes to individual bits.
    function automatic word_t lane_merge(input word_t old_word,
                                         input word_t new_word,
                                         input word_t bit_mask);
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset zero-fill sequencer: sweeps every word once, then raises ready.
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;

    // State, sweep counter and ready flag; ready lags the READY state by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= (state == S_READY);
        end
    end

    // Next-state and clear-write strobe: one zero write per cycle while clearing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        clr_addr  = cnt;
        case (state)
            S_CLEAR: begin
                clr_we = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = S_READY;
                end else begin
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                end
            end
            S_READY: begin
                state_nxt = S_READY;
            end
            default: begin
                state_nxt = S_CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R SRAM model: byte-masked writes, registered reads with
// valid pulses, port0-write/port1-read collision flag and optional bypass.
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned NUM_WMASKS     = DATA_WIDTH / BYTE_WIDTH,
    parameter bit          BYPASS         = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvld0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvld1,
    output logic                  ready,
    output logic                  coll
);

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  accept_ok;
    logic                  wr0_acc;
    logic                  rd0_acc;
    logic                  rd1_acc;
    logic                  in_range0;
    logic                  in_range1;
    logic                  hit;
    logic [DATA_WIDTH-1:0] wbits0;
    logic [DATA_WIDTH-1:0] rd_word0;
    logic [DATA_WIDTH-1:0] rd_word1;
    logic [DATA_WIDTH-1:0] merged0;
    logic [DATA_WIDTH-1:0] rd1_data;

    sram_clear_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .RAM_DEPTH      (RAM_DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Request qualification, range checks and read/merge data paths.
    always_comb begin
        accept_ok = ready & ~rst;
        wr0_acc   = accept_ok & ~csb0 & ~web0;
        rd0_acc   = accept_ok & ~csb0 & web0;
        rd1_acc   = accept_ok & ~csb1;
        in_range0 = ({1'b0, addr0} < DEPTH_EXT);
        in_range1 = ({1'b0, addr1} < DEPTH_EXT);
        hit       = wr0_acc & rd1_acc & (addr0 == addr1);

        wbits0 = '0;
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
            wbits0[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wmask0[i]}};
        end

        rd_word0 = in_range0 ? mem[addr0] : '0;
        rd_word1 = in_range1 ? mem[addr1] : '0;
        merged0  = DATA_WIDTH'(lane_merge(word_t'(rd_word0), word_t'(din0), word_t'(wbits0)));

        // Bypass only applies to a real word; an out-of-range collision still reads 0.
        rd1_data = (hit && BYPASS && in_range1) ? merged0 : rd_word1;
    end

    // Memory write port: the clear sweep owns it while ready is low.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr0_acc && in_range0) begin
            mem[addr0] <= merged0;
        end
    end

    // Read registers, valid pulses and collision flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout0 <= '0;
            dout1 <= '0;
            dvld0 <= 1'b0;
            dvld1 <= 1'b0;
            coll  <= 1'b0;
        end else begin
            dvld0 <= rd0_acc;
            dvld1 <= rd1_acc;
            coll  <= hit;
            if (rd0_acc) begin
                dout0 <= rd_word0;
            end
            if (rd1_acc) begin
                dout1 <= rd1_data;
            end
        end
    end

endmodule
